// File: rtl/satatx_framer_pkg.sv
// Shared SATA link-layer constants and the scrambler step function used by
// both the TX framer and the RX descrambler.
package satatx_framer_pkg;

    localparam logic [15:0] SATA_SCRAMBLER_POLY = 16'ha011;
    localparam logic [15:0] SATA_SCRAMBLER_INIT = 16'hffff;
    localparam logic [31:0] SATA_CRC_INIT       = 32'h52325032;
    localparam logic [31:0] SATA_CRC_POLY       = 32'h04c11db7;

    typedef struct packed {
        logic [31:0] prn;
        logic [15:0] fill;
    } scramble_t;

    // 32 LFSR steps: prn[k] is fill[15] at step k, then shift left and fold in poly.
    function automatic scramble_t sata_scramble(input logic [15:0] fill,
                                                input logic [15:0] poly);
        scramble_t   res;
        logic [15:0] f;
        f       = fill;
        res.prn = 32'h0000_0000;
        for (int k = 0; k < 32; k++) begin
            res.prn[k] = f[15];
            f          = {f[14:0], 1'b0} ^ (f[15] ? poly : 16'h0000);
        end
        res.fill = f;
        return res;
    endfunction

endpackage

// File: rtl/satatx_crc32.sv
// Combinational next-CRC over one 32-bit dword, MSB first, no reflection.
// Shared between the TX framer and the RX CRC checker.
module satatx_crc32
    import satatx_framer_pkg::*;
#(
    parameter logic [31:0] POLY = SATA_CRC_POLY
) (
    input  logic [31:0] crc,
    input  logic [31:0] data,
    output logic [31:0] crc_next
);

    function automatic logic [31:0] crc_step(input logic [31:0] c_in,
                                             input logic [31:0] d_in);
        logic [31:0] c;
        c = c_in;
        for (int i = 31; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ d_in[i]) ? POLY : 32'h0000_0000);
        end
        return c;
    endfunction

    assign crc_next = crc_step(crc, data);

endmodule

// File: rtl/satatx_framer.sv
// TX link-layer framer: scrambles a FIS payload, appends its scrambled CRC and
// drops overlong frames while still terminating them with a CRC dword.
module satatx_framer
    import satatx_framer_pkg::*;
#(
    parameter logic [15:0] POLYNOMIAL   = SATA_SCRAMBLER_POLY,
    parameter logic [15:0] INITIAL      = SATA_SCRAMBLER_INIT,
    parameter logic [31:0] CRC_INIT     = SATA_CRC_INIT,
    parameter logic [31:0] CRC_POLY     = SATA_CRC_POLY,
    parameter int          MAX_DWORDS   = 2049,
    parameter bit          OPT_LOWPOWER = 1'b1
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic        i_cfg_scrambler_en,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        o_err_overlength
);

    localparam int                 COUNT_W   = $clog2(MAX_DWORDS + 2);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_DWORDS + 1);
    localparam logic [COUNT_W-1:0] COUNT_LIM = COUNT_W'(MAX_DWORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2,
        ST_CRC  = 2'd3
    } state_t;

    state_t             state_r;
    logic [15:0]        fill_r;
    logic [31:0]        crc_r;
    logic [COUNT_W-1:0] count_r;
    logic               m_valid_r;
    logic [31:0]        m_data_r;
    logic               m_last_r;
    logic               err_r;

    logic               can_load_s;
    logic               ready_s;
    logic               accept_s;
    scramble_t          scr_s;
    logic [31:0]        prn_s;
    logic [31:0]        crc_next_s;
    logic               overlength_s;
    logic [COUNT_W-1:0] count_inc_s;

    satatx_crc32 #(
        .POLY (CRC_POLY)
    ) u_crc (
        .crc      (crc_r),
        .data     (S_AXIS_TDATA),
        .crc_next (crc_next_s)
    );

    // Handshake, scrambler keystream and dword-count terms for the current cycle
    always_comb begin
        can_load_s = !m_valid_r || M_AXIS_TREADY;
        case (state_r)
            ST_IDLE: ready_s = can_load_s;
            ST_DATA: ready_s = can_load_s;
            ST_DROP: ready_s = 1'b1;
            ST_CRC:  ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
        accept_s = S_AXIS_TVALID && ready_s;
        scr_s    = sata_scramble(fill_r, POLYNOMIAL);
        if (i_cfg_scrambler_en) begin
            prn_s = scr_s.prn;
        end else begin
            prn_s = 32'h0000_0000;
        end
        // count_r holds dwords already taken, so this flags dword MAX_DWORDS+1
        overlength_s = (count_r == COUNT_LIM);
        if (count_r < COUNT_MAX) begin
            count_inc_s = count_r + COUNT_W'(1);
        end else begin
            count_inc_s = count_r;
        end
    end

    // Framer state machine with registered output stage
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_r   <= ST_IDLE;
            fill_r    <= INITIAL;
            crc_r     <= CRC_INIT;
            count_r   <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= 32'h0000_0000;
            m_last_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            if (can_load_s) begin
                m_valid_r <= 1'b0;
                if (OPT_LOWPOWER) begin
                    m_data_r <= 32'h0000_0000;
                    m_last_r <= 1'b0;
                end
            end
            case (state_r)
                ST_IDLE, ST_DATA: begin
                    if (accept_s) begin
                        if (overlength_s) begin
                            err_r   <= 1'b1;
                            count_r <= count_inc_s;
                            state_r <= S_AXIS_TLAST ? ST_CRC : ST_DROP;
                        end else begin
                            m_valid_r <= 1'b1;
                            m_data_r  <= S_AXIS_TDATA ^ prn_s;
                            m_last_r  <= 1'b0;
                            crc_r     <= crc_next_s;
                            fill_r    <= scr_s.fill;
                            count_r   <= count_inc_s;
                            state_r   <= S_AXIS_TLAST ? ST_CRC : ST_DATA;
                        end
                    end
                end
                ST_DROP: begin
                    if (accept_s) begin
                        count_r <= count_inc_s;
                        if (S_AXIS_TLAST) begin
                            state_r <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (can_load_s) begin
                        m_valid_r <= 1'b1;
                        m_data_r  <= crc_r ^ prn_s;
                        m_last_r  <= 1'b1;
                        fill_r    <= INITIAL;
                        crc_r     <= CRC_INIT;
                        count_r   <= '0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign S_AXIS_TREADY    = ready_s;
    assign M_AXIS_TVALID    = m_valid_r;
    assign M_AXIS_TDATA     = m_data_r;
    assign M_AXIS_TLAST     = m_last_r;
    assign o_err_overlength = err_r;

endmodule
